// File: rtl/idu_pkg.sv
// ============================================================================
// Module : idu_pkg
// Brief  : Opcode table, one-hot type/pipe codes and decoded bundle for the
//          buffered decode stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package idu_pkg;

  localparam int unsigned MAX_XLEN = 64;

  localparam logic [6:0] R_ALU64    = 7'b0110011;
  localparam logic [6:0] R_ALU32    = 7'b0111011;
  localparam logic [6:0] I_ALU64    = 7'b0010011;
  localparam logic [6:0] I_ALU32    = 7'b0011011;
  localparam logic [6:0] I_MEMLOAD  = 7'b0000011;
  localparam logic [6:0] I_ENV      = 7'b1110011;
  localparam logic [6:0] I_JALR     = 7'b1100111;
  localparam logic [6:0] S_MEMSTORE = 7'b0100011;
  localparam logic [6:0] B_BRANCH   = 7'b1100011;
  localparam logic [6:0] U_AUIPC    = 7'b0010111;
  localparam logic [6:0] U_LUI      = 7'b0110111;
  localparam logic [6:0] J_JAL      = 7'b1101111;

  localparam logic [5:0] TYPE_R = 6'b100000;
  localparam logic [5:0] TYPE_I = 6'b010000;
  localparam logic [5:0] TYPE_S = 6'b001000;
  localparam logic [5:0] TYPE_B = 6'b000100;
  localparam logic [5:0] TYPE_U = 6'b000010;
  localparam logic [5:0] TYPE_J = 6'b000001;

  localparam logic [4:0] PIPE_ALU = 5'b10000;
  localparam logic [4:0] PIPE_MXU = 5'b01000;
  localparam logic [4:0] PIPE_BJU = 5'b00100;
  localparam logic [4:0] PIPE_LSU = 5'b00010;
  localparam logic [4:0] PIPE_CP0 = 5'b00001;

  // pc/imm are carried at the widest XLEN; the top keeps the low XLEN bits
  typedef struct packed {
    logic [6:0]          opcode;
    logic [6:0]          funct7;
    logic [2:0]          funct3;
    logic [MAX_XLEN-1:0] pc;
    logic                src1_vld;
    logic [4:0]          src1;
    logic                src2_vld;
    logic [4:0]          src2;
    logic                dst_vld;
    logic [4:0]          dst;
    logic                imm_vld;
    logic [MAX_XLEN-1:0] imm;
    logic [5:0]          itype;
    logic [4:0]          pipe;
    logic                ras;
    logic                illegal;
  } dec_bundle_t;

endpackage

`default_nettype wire

// File: rtl/idu_id_buf_if.sv
// ============================================================================
// Module : idu_id_buf_if
// Brief  : IFU-side handshake plus decode output slot of the decode stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface idu_id_buf_if #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
);
  logic                         ifu_idu_id_inst_vld;
  logic [XLEN-1:0]              ifu_idu_id_inst_pc;
  logic [31:0]                  ifu_idu_id_inst;
  logic                         idu_ifu_id_rdy;
  logic                         decode_rdy;
  logic                         decode_vld;
  logic [6:0]                   decode_opcode;
  logic [6:0]                   decode_funct7;
  logic [2:0]                   decode_funct3;
  logic [XLEN-1:0]              decode_pc;
  logic                         decode_src1_vld;
  logic [4:0]                   decode_src1;
  logic                         decode_src2_vld;
  logic [4:0]                   decode_src2;
  logic                         decode_dst_vld;
  logic [4:0]                   decode_dst;
  logic                         decode_imm_vld;
  logic [XLEN-1:0]              decode_imm;
  logic [5:0]                   decode_type;
  logic [4:0]                   decode_pipe;
  logic                         decode_ras;
  logic                         decode_illegal;
  logic [$clog2(DEPTH+1)-1:0]   buf_cnt;
  logic                         iid_req;
  logic                         preg_req;

  modport master (
    output ifu_idu_id_inst_vld, ifu_idu_id_inst_pc, ifu_idu_id_inst, decode_rdy,
    input  idu_ifu_id_rdy, decode_vld, decode_opcode, decode_funct7, decode_funct3,
           decode_pc, decode_src1_vld, decode_src1, decode_src2_vld, decode_src2,
           decode_dst_vld, decode_dst, decode_imm_vld, decode_imm, decode_type,
           decode_pipe, decode_ras, decode_illegal, buf_cnt, iid_req, preg_req
  );

  modport slave (
    input  ifu_idu_id_inst_vld, ifu_idu_id_inst_pc, ifu_idu_id_inst, decode_rdy,
    output idu_ifu_id_rdy, decode_vld, decode_opcode, decode_funct7, decode_funct3,
           decode_pc, decode_src1_vld, decode_src1, decode_src2_vld, decode_src2,
           decode_dst_vld, decode_dst, decode_imm_vld, decode_imm, decode_type,
           decode_pipe, decode_ras, decode_illegal, buf_cnt, iid_req, preg_req
  );
endinterface

`default_nettype wire

// File: rtl/idu_id_dec.sv
// ============================================================================
// Module : idu_id_dec
// Brief  : Combinational instruction decoder producing the decoded bundle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module idu_id_dec
  import idu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  output dec_bundle_t     dec
);

  localparam logic IS_RV32 = (XLEN == 32);

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        funct7_ok;
  logic [63:0] imm_i;
  logic [63:0] imm_s;
  logic [63:0] imm_b;
  logic [63:0] imm_u;
  logic [63:0] imm_j;

  assign opcode    = inst[6:0];
  assign funct7    = inst[31:25];
  assign rd        = inst[11:7];
  assign rs1       = inst[19:15];
  assign rs2       = inst[24:20];
  assign funct7_ok = (funct7 == 7'b0000000) || (funct7 == 7'b0100000) ||
                     (funct7 == 7'b0000001);

  assign imm_i = {{52{inst[31]}}, inst[31:20]};
  assign imm_s = {{52{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{52{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {{32{inst[31]}}, inst[31:12], 12'b0};
  assign imm_j = {{44{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

  always_comb begin
    dec              = '0;
    dec.opcode       = opcode;
    dec.funct7       = funct7;
    dec.funct3       = inst[14:12];
    dec.pc[XLEN-1:0] = pc;
    case (opcode)
      R_ALU64, R_ALU32: begin
        dec.itype    = TYPE_R;
        dec.src1_vld = 1'b1;
        dec.src1     = rs1;
        dec.src2_vld = 1'b1;
        dec.src2     = rs2;
        dec.dst      = rd;
        dec.pipe     = funct7[0] ? PIPE_MXU : PIPE_ALU;
        dec.illegal  = !funct7_ok || (IS_RV32 && (opcode == R_ALU32));
      end
      I_ALU64, I_ALU32, I_MEMLOAD, I_ENV, I_JALR: begin
        dec.itype    = TYPE_I;
        dec.src1_vld = 1'b1;
        dec.src1     = rs1;
        dec.dst      = rd;
        dec.imm_vld  = 1'b1;
        dec.imm      = imm_i;
        dec.ras      = (opcode == I_JALR);
        dec.illegal  = IS_RV32 && (opcode == I_ALU32);
        dec.pipe     = (opcode == I_MEMLOAD) ? PIPE_LSU :
                       (opcode == I_ENV)     ? PIPE_CP0 :
                       (opcode == I_JALR)    ? PIPE_BJU : PIPE_ALU;
      end
      S_MEMSTORE, B_BRANCH: begin
        dec.itype    = (opcode == S_MEMSTORE) ? TYPE_S : TYPE_B;
        dec.pipe     = (opcode == S_MEMSTORE) ? PIPE_LSU : PIPE_BJU;
        dec.src1_vld = 1'b1;
        dec.src1     = rs1;
        dec.src2_vld = 1'b1;
        dec.src2     = rs2;
        dec.imm_vld  = 1'b1;
        dec.imm      = (opcode == S_MEMSTORE) ? imm_s : imm_b;
      end
      U_AUIPC, U_LUI, J_JAL: begin
        dec.itype    = (opcode == J_JAL) ? TYPE_J : TYPE_U;
        dec.pipe     = (opcode == J_JAL) ? PIPE_BJU : PIPE_ALU;
        dec.ras      = (opcode == J_JAL);
        dec.dst      = rd;
        dec.imm_vld  = 1'b1;
        dec.imm      = (opcode == J_JAL) ? imm_j : imm_u;
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.dst_vld = (dec.dst != 5'd0);
    // Illegal entries keep only raw fields and pc so the trap handler sees them
    if (dec.illegal) begin
      dec.itype    = '0;
      dec.pipe     = '0;
      dec.src1_vld = 1'b0;
      dec.src1     = '0;
      dec.src2_vld = 1'b0;
      dec.src2     = '0;
      dec.dst_vld  = 1'b0;
      dec.dst      = '0;
      dec.imm_vld  = 1'b0;
      dec.imm      = '0;
      dec.ras      = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/idu_id_buf.sv
// ============================================================================
// Module : idu_id_buf
// Brief  : Buffered decode stage: DEPTH-entry FIFO feeding a registered slot.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module idu_id_buf
  import idu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_clk,
  input  logic        rtu_global_flush,
  idu_id_buf_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [XLEN+31:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             slot_vld;
  dec_bundle_t      slot;
  dec_bundle_t      dec_next;
  logic             in_rdy;
  logic             in_fire;
  logic             slot_free;
  logic             deq;
  logic             bypass;
  logic             enq;
  logic [31:0]      sel_inst;
  logic [XLEN-1:0]  sel_pc;

  assign in_rdy    = (cnt < FULL_CNT);
  assign in_fire   = bus.ifu_idu_id_inst_vld & in_rdy;
  assign slot_free = !slot_vld | bus.decode_rdy;
  assign deq       = slot_free & (cnt != '0);
  assign bypass    = slot_free & (cnt == '0) & in_fire;
  assign enq       = in_fire & !bypass;
  assign {sel_inst, sel_pc} = deq ? mem[rd_ptr]
                                  : {bus.ifu_idu_id_inst, bus.ifu_idu_id_inst_pc};

  idu_id_dec #(.XLEN(XLEN)) u_dec (
    .inst (sel_inst),
    .pc   (sel_pc),
    .dec  (dec_next)
  );

  always_ff @(posedge clk) begin
    if (enq && !rtu_global_flush) begin
      mem[wr_ptr] <= {bus.ifu_idu_id_inst, bus.ifu_idu_id_inst_pc};
    end
  end

  always_ff @(posedge clk or posedge rst_clk) begin
    if (rst_clk) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (rtu_global_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      if (enq && !deq) begin
        cnt <= cnt + 1'b1;
      end else if (!enq && deq) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Flush wins over decode_rdy and wipes the slot contents, not just valid
  always_ff @(posedge clk or posedge rst_clk) begin
    if (rst_clk) begin
      slot_vld <= 1'b0;
      slot     <= '0;
    end else if (rtu_global_flush) begin
      slot_vld <= 1'b0;
      slot     <= '0;
    end else if (slot_free) begin
      slot_vld <= deq | bypass;
      if (deq || bypass) slot <= dec_next;
    end
  end

  assign bus.idu_ifu_id_rdy  = in_rdy;
  assign bus.decode_vld      = slot_vld;
  assign bus.decode_opcode   = slot.opcode;
  assign bus.decode_funct7   = slot.funct7;
  assign bus.decode_funct3   = slot.funct3;
  assign bus.decode_pc       = slot.pc[XLEN-1:0];
  assign bus.decode_src1_vld = slot.src1_vld;
  assign bus.decode_src1     = slot.src1;
  assign bus.decode_src2_vld = slot.src2_vld;
  assign bus.decode_src2     = slot.src2;
  assign bus.decode_dst_vld  = slot.dst_vld;
  assign bus.decode_dst      = slot.dst;
  assign bus.decode_imm_vld  = slot.imm_vld;
  assign bus.decode_imm      = slot.imm[XLEN-1:0];
  assign bus.decode_type     = slot.itype;
  assign bus.decode_pipe     = slot.pipe;
  assign bus.decode_ras      = slot.ras;
  assign bus.decode_illegal  = slot.illegal;
  assign bus.buf_cnt         = cnt;
  assign bus.iid_req         = slot_vld;
  assign bus.preg_req        = slot_vld & slot.dst_vld;

endmodule

`default_nettype wire

// File: tb/tb_idu_id_buf.sv
// ============================================================================
// Module : tb_idu_id_buf
// Brief  : Self-checking bench for idu_id_buf (XLEN=64 and XLEN=32 instances).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_idu_id_buf;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  idu_id_buf_if #(.XLEN(64), .DEPTH(4)) b64 ();
  idu_id_buf_if #(.XLEN(32), .DEPTH(4)) b32 ();

  idu_id_buf #(.XLEN(64), .DEPTH(4)) dut64 (
    .clk(clk), .rst_clk(rst), .rtu_global_flush(flush), .bus(b64.slave)
  );
  idu_id_buf #(.XLEN(32), .DEPTH(4)) dut32 (
    .clk(clk), .rst_clk(rst), .rtu_global_flush(flush), .bus(b32.slave)
  );

  typedef struct {
    logic [63:0] pc;
    logic [4:0]  rd;
    logic [63:0] imm;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [11:0] imm);
    return {imm, 5'd0, 3'b000, rd, 7'b0010011};
  endfunction

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // Pushes an ADDI on b64 this cycle if the DUT accepts it
  task automatic drive_addi(input logic [4:0] rd, input logic [11:0] imm, input logic [63:0] pc);
    exp_t e;
    b64.ifu_idu_id_inst_vld = 1'b1;
    b64.ifu_idu_id_inst     = addi(rd, imm);
    b64.ifu_idu_id_inst_pc  = pc;
    if (b64.idu_ifu_id_rdy) begin
      e.pc  = pc;
      e.rd  = rd;
      e.imm = {{52{imm[11]}}, imm};
      sbq.push_back(e);
    end
  endtask

  task automatic test_addi;
    b64.decode_rdy = 1'b1;
    b64.ifu_idu_id_inst_vld = 1'b1;
    b64.ifu_idu_id_inst     = 32'hFFF00293;
    b64.ifu_idu_id_inst_pc  = 64'h8000_0000;
    cyc();
    b64.ifu_idu_id_inst_vld = 1'b0;
    total++; if (b64.decode_vld !== 1'b1) begin bad++; $display("FAIL addi_vld got=%0h want=1", b64.decode_vld); end
    total++; if (b64.decode_type !== 6'b010000) begin bad++; $display("FAIL addi_type got=%b want=010000", b64.decode_type); end
    total++; if (b64.decode_pipe !== 5'b10000) begin bad++; $display("FAIL addi_pipe got=%b want=10000", b64.decode_pipe); end
    total++; if (b64.decode_dst !== 5'd5 || b64.decode_dst_vld !== 1'b1) begin bad++; $display("FAIL addi_dst got=%0d/%0d want=5/1", b64.decode_dst, b64.decode_dst_vld); end
    total++; if (b64.decode_imm !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL addi_imm got=%h want=ffffffffffffffff", b64.decode_imm); end
    total++; if (b64.decode_pc !== 64'h8000_0000) begin bad++; $display("FAIL addi_pc got=%h want=80000000", b64.decode_pc); end
    total++; if (b64.decode_src1_vld !== 1'b1 || b64.decode_src2_vld !== 1'b0 || b64.decode_illegal !== 1'b0) begin bad++; $display("FAIL addi_flags got=%b%b%b want=100", b64.decode_src1_vld, b64.decode_src2_vld, b64.decode_illegal); end
    total++; if (b64.preg_req !== 1'b1 || b64.iid_req !== 1'b1) begin bad++; $display("FAIL addi_req got=%b%b want=11", b64.preg_req, b64.iid_req); end
    cyc();
    total++; if (b64.decode_vld !== 1'b0) begin bad++; $display("FAIL addi_drain got=%0h want=0", b64.decode_vld); end
  endtask

  task automatic test_backpressure;
    int cycles;
    exp_t e;
    b64.decode_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++; if (b64.idu_ifu_id_rdy !== 1'b1) begin bad++; $display("FAIL bp_rdy_%0d got=%0h want=1", i, b64.idu_ifu_id_rdy); end
      drive_addi(5'(i + 1), 12'(i * 3), 64'h100 + 64'(4 * i));
      cyc();
    end
    b64.ifu_idu_id_inst_vld = 1'b0;
    total++; if (b64.buf_cnt !== 3'd4) begin bad++; $display("FAIL bp_cnt got=%0d want=4", b64.buf_cnt); end
    total++; if (b64.idu_ifu_id_rdy !== 1'b0) begin bad++; $display("FAIL bp_full_rdy got=%0h want=0", b64.idu_ifu_id_rdy); end
    // Offer one more while full: it must not be taken, and the slot must hold
    b64.ifu_idu_id_inst_vld = 1'b1;
    b64.ifu_idu_id_inst     = addi(5'd30, 12'h7FF);
    b64.ifu_idu_id_inst_pc  = 64'hBAD0;
    cyc();
    b64.ifu_idu_id_inst_vld = 1'b0;
    total++; if (b64.buf_cnt !== 3'd4) begin bad++; $display("FAIL bp_nofire got=%0d want=4", b64.buf_cnt); end
    total++; if (b64.decode_vld !== 1'b1 || b64.decode_pc !== 64'h100 || b64.decode_dst !== 5'd1) begin bad++; $display("FAIL bp_hold got=%0h/%h/%0d want=1/100/1", b64.decode_vld, b64.decode_pc, b64.decode_dst); end
    b64.decode_rdy = 1'b1;
    cycles = 0;
    for (int k = 0; k < 12 && sbq.size() > 0; k++) begin
      if (b64.decode_vld && b64.decode_rdy) begin
        e = sbq.pop_front();
        total++; if (b64.decode_pc !== e.pc || b64.decode_dst !== e.rd || b64.decode_imm !== e.imm) begin bad++; $display("FAIL bp_order got=%h/%0d/%h want=%h/%0d/%h", b64.decode_pc, b64.decode_dst, b64.decode_imm, e.pc, e.rd, e.imm); end
      end
      cycles++;
      cyc();
    end
    total++; if (cycles !== 5 || sbq.size() !== 0) begin bad++; $display("FAIL bp_rate got=%0d/%0d want=5/0", cycles, sbq.size()); end
    total++; if (b64.idu_ifu_id_rdy !== 1'b1 || b64.decode_vld !== 1'b0) begin bad++; $display("FAIL bp_empty got=%0h/%0h want=1/0", b64.idu_ifu_id_rdy, b64.decode_vld); end
  endtask

  task automatic test_flush;
    b64.decode_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b64.ifu_idu_id_inst_vld = 1'b1;
      b64.ifu_idu_id_inst     = addi(5'(i + 7), 12'(i));
      b64.ifu_idu_id_inst_pc  = 64'h200 + 64'(4 * i);
      cyc();
    end
    total++; if (b64.buf_cnt !== 3'd3) begin bad++; $display("FAIL fl_pre_cnt got=%0d want=3", b64.buf_cnt); end
    flush = 1'b1;
    b64.ifu_idu_id_inst     = addi(5'd9, 12'h55);
    b64.ifu_idu_id_inst_pc  = 64'hDEAD_0000;
    cyc();
    flush = 1'b0;
    b64.ifu_idu_id_inst_vld = 1'b0;
    total++; if (b64.decode_vld !== 1'b0 || b64.buf_cnt !== 3'd0) begin bad++; $display("FAIL fl_clear got=%0h/%0d want=0/0", b64.decode_vld, b64.buf_cnt); end
    total++; if (b64.decode_pc !== 64'd0 || b64.decode_opcode !== 7'd0 || b64.decode_dst !== 5'd0) begin bad++; $display("FAIL fl_fields got=%h/%h/%0d want=0/0/0", b64.decode_pc, b64.decode_opcode, b64.decode_dst); end
    total++; if (b64.idu_ifu_id_rdy !== 1'b1) begin bad++; $display("FAIL fl_rdy got=%0h want=1", b64.idu_ifu_id_rdy); end
    b64.decode_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      total++; if (b64.decode_vld !== 1'b0) begin bad++; $display("FAIL fl_ghost_%0d got=%0h/%h want=0", k, b64.decode_vld, b64.decode_pc); end
    end
  endtask

  task automatic test_jal_illegal;
    b64.decode_rdy = 1'b1;
    b64.ifu_idu_id_inst_vld = 1'b1;
    b64.ifu_idu_id_inst     = 32'hFFDFF0EF;
    b64.ifu_idu_id_inst_pc  = 64'h2000;
    cyc();
    total++; if (b64.decode_ras !== 1'b1 || b64.decode_type !== 6'b000001) begin bad++; $display("FAIL jal_ras_type got=%0h/%b want=1/000001", b64.decode_ras, b64.decode_type); end
    total++; if (b64.decode_dst !== 5'd1 || b64.decode_pipe !== 5'b00100) begin bad++; $display("FAIL jal_dst_pipe got=%0d/%b want=1/00100", b64.decode_dst, b64.decode_pipe); end
    total++; if (b64.decode_imm !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL jal_imm got=%h want=fffffffffffffffc", b64.decode_imm); end
    b64.ifu_idu_id_inst    = 32'h0000007F;
    b64.ifu_idu_id_inst_pc = 64'h2004;
    cyc();
    b64.ifu_idu_id_inst_vld = 1'b0;
    total++; if (b64.decode_vld !== 1'b1 || b64.decode_illegal !== 1'b1) begin bad++; $display("FAIL ill_flag got=%0h/%0h want=1/1", b64.decode_vld, b64.decode_illegal); end
    total++; if (b64.decode_type !== 6'd0 || b64.decode_pipe !== 5'd0 || b64.decode_imm !== 64'd0) begin bad++; $display("FAIL ill_zero got=%b/%b/%h want=0/0/0", b64.decode_type, b64.decode_pipe, b64.decode_imm); end
    total++; if (b64.decode_opcode !== 7'h7F || b64.decode_pc !== 64'h2004) begin bad++; $display("FAIL ill_keep got=%h/%h want=7f/2004", b64.decode_opcode, b64.decode_pc); end
    cyc();
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int pops;
    pops = 0;
    b64.decode_rdy = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (b64.decode_vld && b64.decode_rdy) begin
        e = sbq.pop_front();
        pops++;
        total++; if (b64.decode_pc !== e.pc || b64.decode_dst !== e.rd || b64.decode_imm !== e.imm) begin bad++; $display("FAIL b2b_data got=%h/%0d/%h want=%h/%0d/%h", b64.decode_pc, b64.decode_dst, b64.decode_imm, e.pc, e.rd, e.imm); end
      end
      if (i >= 1 && i <= 8) begin
        total++; if (b64.decode_vld !== 1'b1 || b64.buf_cnt !== 3'd0) begin bad++; $display("FAIL b2b_rate_%0d got=%0h/%0d want=1/0", i, b64.decode_vld, b64.buf_cnt); end
      end
      if (i < 8) drive_addi(5'(i % 31 + 1), 12'(i * 37 - 100), 64'h4000 + 64'(4 * i));
      else b64.ifu_idu_id_inst_vld = 1'b0;
      cyc();
    end
    total++; if (pops !== 8 || sbq.size() !== 0) begin bad++; $display("FAIL b2b_count got=%0d/%0d want=8/0", pops, sbq.size()); end
  endtask

  task automatic test_random;
    exp_t e;
    logic [63:0] pc;
    pc = 64'h9000;
    for (int i = 0; i < 80; i++) begin
      b64.decode_rdy = (i >= 60) ? 1'b1 : 1'($urandom_range(0, 2) != 0);
      if (b64.decode_vld && b64.decode_rdy) begin
        if (sbq.size() == 0) begin
          total++; bad++; $display("FAIL rnd_extra got=%h want=none", b64.decode_pc);
        end else begin
          e = sbq.pop_front();
          total++; if (b64.decode_pc !== e.pc || b64.decode_dst !== e.rd || b64.decode_imm !== e.imm) begin bad++; $display("FAIL rnd_data got=%h/%0d/%h want=%h/%0d/%h", b64.decode_pc, b64.decode_dst, b64.decode_imm, e.pc, e.rd, e.imm); end
        end
      end
      if (i < 60 && $urandom_range(0, 3) != 0) begin
        drive_addi(5'($urandom_range(1, 31)), 12'($urandom), pc);
        pc = pc + 64'd4;
      end else begin
        b64.ifu_idu_id_inst_vld = 1'b0;
      end
      cyc();
    end
    total++; if (sbq.size() !== 0 || b64.decode_vld !== 1'b0) begin bad++; $display("FAIL rnd_drain got=%0d/%0h want=0/0", sbq.size(), b64.decode_vld); end
  endtask

  task automatic test_xlen32;
    b32.decode_rdy = 1'b1;
    b32.ifu_idu_id_inst_vld = 1'b1;
    b32.ifu_idu_id_inst     = 32'h00B5053B;
    b32.ifu_idu_id_inst_pc  = 32'h1000;
    cyc();
    total++; if (b32.decode_vld !== 1'b1 || b32.decode_illegal !== 1'b1) begin bad++; $display("FAIL x32_addw_ill got=%0h/%0h want=1/1", b32.decode_vld, b32.decode_illegal); end
    total++; if (b32.decode_type !== 6'd0 || b32.decode_pipe !== 5'd0 || b32.decode_dst_vld !== 1'b0) begin bad++; $display("FAIL x32_addw_zero got=%b/%b/%0h want=0/0/0", b32.decode_type, b32.decode_pipe, b32.decode_dst_vld); end
    total++; if (b32.decode_opcode !== 7'h3B || b32.decode_pc !== 32'h1000) begin bad++; $display("FAIL x32_addw_keep got=%h/%h want=3b/1000", b32.decode_opcode, b32.decode_pc); end
    b32.ifu_idu_id_inst    = 32'h02B50533;
    b32.ifu_idu_id_inst_pc = 32'h1004;
    cyc();
    total++; if (b32.decode_pipe !== 5'b01000 || b32.decode_illegal !== 1'b0) begin bad++; $display("FAIL x32_mul got=%b/%0h want=01000/0", b32.decode_pipe, b32.decode_illegal); end
    total++; if (b32.decode_type !== 6'b100000 || b32.decode_dst !== 5'd10 || b32.decode_src2 !== 5'd11) begin bad++; $display("FAIL x32_mul_regs got=%b/%0d/%0d want=100000/10/11", b32.decode_type, b32.decode_dst, b32.decode_src2); end
    b32.ifu_idu_id_inst    = 32'hFFF00293;
    b32.ifu_idu_id_inst_pc = 32'h1008;
    cyc();
    b32.ifu_idu_id_inst_vld = 1'b0;
    total++; if (b32.decode_imm !== 32'hFFFF_FFFF || b32.decode_pipe !== 5'b10000) begin bad++; $display("FAIL x32_addi got=%h/%b want=ffffffff/10000", b32.decode_imm, b32.decode_pipe); end
    cyc();
  endtask

  task automatic test_reset;
    b64.decode_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b64.ifu_idu_id_inst_vld = 1'b1;
      b64.ifu_idu_id_inst     = addi(5'(i + 3), 12'hF00);
      b64.ifu_idu_id_inst_pc  = 64'h700 + 64'(4 * i);
      cyc();
    end
    b64.ifu_idu_id_inst_vld = 1'b0;
    total++; if (b64.buf_cnt !== 3'd2 || b64.decode_vld !== 1'b1) begin bad++; $display("FAIL rst_pre got=%0d/%0h want=2/1", b64.buf_cnt, b64.decode_vld); end
    rst = 1'b1;
    #2;
    total++; if (b64.decode_vld !== 1'b0 || b64.buf_cnt !== 3'd0 || b64.idu_ifu_id_rdy !== 1'b1) begin bad++; $display("FAIL rst_ctl got=%0h/%0d/%0h want=0/0/1", b64.decode_vld, b64.buf_cnt, b64.idu_ifu_id_rdy); end
    total++; if (b64.decode_pc !== 64'd0 || b64.decode_imm !== 64'd0 || b64.decode_type !== 6'd0 || b64.decode_pipe !== 5'd0) begin bad++; $display("FAIL rst_fields got=%h/%h/%b/%b want=0", b64.decode_pc, b64.decode_imm, b64.decode_type, b64.decode_pipe); end
    total++; if (b64.decode_dst !== 5'd0 || b64.decode_dst_vld !== 1'b0 || b64.preg_req !== 1'b0 || b64.iid_req !== 1'b0 || b64.decode_opcode !== 7'd0) begin bad++; $display("FAIL rst_misc got=%0d/%0h/%0h/%0h/%h want=0", b64.decode_dst, b64.decode_dst_vld, b64.preg_req, b64.iid_req, b64.decode_opcode); end
    cyc();
    rst = 1'b0;
    b64.decode_rdy = 1'b1;
    cyc();
    total++; if (b64.decode_vld !== 1'b0 || b64.buf_cnt !== 3'd0) begin bad++; $display("FAIL rst_after got=%0h/%0d want=0/0", b64.decode_vld, b64.buf_cnt); end
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    b64.ifu_idu_id_inst_vld = 1'b0;
    b64.ifu_idu_id_inst     = '0;
    b64.ifu_idu_id_inst_pc  = '0;
    b64.decode_rdy          = 1'b0;
    b32.ifu_idu_id_inst_vld = 1'b0;
    b32.ifu_idu_id_inst     = '0;
    b32.ifu_idu_id_inst_pc  = '0;
    b32.decode_rdy          = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    test_addi();
    test_backpressure();
    test_flush();
    test_jal_illegal();
    test_back_to_back();
    test_random();
    test_xlen32();
    test_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
